// File: rtl/modexp_pkg.sv
// Shared definitions for the modular exponentiation controller and its
// Montgomery multiplier.
//   - default operand / exponent / length widths
//   - controller state encoding plus the ISSUE/WAIT phase of a multiply
//   - multiplier state encoding
//   - ONE: the Montgomery-domain exit operand (value 1)
package modexp_pkg;

  localparam int DEF_WIDTH     = 1024;
  localparam int DEF_EXP_WIDTH = 1024;
  localparam int DEF_LEN_W     = 11;

  // Value 1 at the default width; used as the second operand when converting
  // the accumulator out of the Montgomery domain.
  localparam logic [DEF_WIDTH-1:0] ONE = {{(DEF_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TOMONT   = 3'd1,
    ST_SQ       = 3'd2,
    ST_MUL      = 3'd3,
    ST_FROMMONT = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // Every multiply state is split into a one-cycle ISSUE and a WAIT that
  // lasts until the multiplier reports done.
  typedef enum logic {
    PH_ISSUE = 1'b0,
    PH_WAIT  = 1'b1
  } phase_t;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_RUN  = 2'd1,
    MS_FIN  = 2'd2
  } mont_state_t;

endpackage

// File: rtl/modexp_ctrl_montgomery.sv
// montgomery: bit-serial Montgomery multiplier, result = a*b*2^-WIDTH mod m.
// Requires a, b < m and m odd. One bit of a is consumed per cycle, then one
// cycle performs the final conditional subtraction.
// Latency: done is high WIDTH+2 cycles after the cycle in which start is high.
// Operands must be held stable from start until done.
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   start            one-cycle request, sampled only when idle
//   in_a, in_b, in_m operands and odd modulus
//   result           product, valid when done is high, held afterwards
//   done             one-cycle completion pulse
module montgomery
  import modexp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mont_state_t      state;
  logic [CNT_W-1:0] cnt;
  // Two guard bits: acc stays below 2m, the intermediate sum below 4m.
  logic [WIDTH+1:0] acc;

  logic             a_bit;
  logic [WIDTH+1:0] b_ext;
  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] sum_ab;
  logic [WIDTH+1:0] sum_abm;
  logic [WIDTH+1:0] acc_next;
  logic [WIDTH+1:0] acc_red;

  assign a_bit = 1'(in_a >> cnt);
  assign b_ext = {2'b00, in_b};
  assign m_ext = {2'b00, in_m};

  // acc <- (acc + a_i*b + q*m) / 2, q chosen so the sum is even.
  assign sum_ab   = acc + (a_bit ? b_ext : '0);
  assign sum_abm  = sum_ab + (sum_ab[0] ? m_ext : '0);
  assign acc_next = sum_abm >> 1;

  // Final conditional subtraction brings acc from [0, 2m) into [0, m).
  assign acc_red = (acc >= m_ext) ? (acc - m_ext) : acc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= MS_IDLE;
      cnt    <= '0;
      acc    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MS_IDLE: begin
          if (start) begin
            acc   <= '0;
            cnt   <= '0;
            state <= MS_RUN;
          end
        end
        MS_RUN: begin
          acc <= acc_next;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= MS_FIN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        MS_FIN: begin
          result <= WIDTH'(acc_red);
          done   <= 1'b1;
          state  <= MS_IDLE;
        end
        default: state <= MS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: left-to-right square-and-multiply, result = x^e mod m.
// The host supplies R mod m and R^2 mod m (R = 2^WIDTH). All reduction is done
// by the owned montgomery instance; this block only sequences multiplies and
// muxes their operands.
// Ports:
//   clk, resetn  clock, asynchronous active-low reset (also resets mont_inst)
//   start        one-cycle request, sampled only in IDLE
//   in_x         base (< m)          in_e      exponent
//   in_e_len     significant exponent bits (0 means e = 0)
//   in_m         odd modulus         in_r, in_r2  R mod m, R^2 mod m
//   result       x^e mod m, held until the next accepted start
//   done         one-cycle pulse when result becomes valid
//   busy         high from the cycle after acceptance through the done cycle
// Handshake: start is a request that is accepted only when busy is low; a
// request while busy is dropped. done pulses exactly once per accepted start,
// in the last busy cycle.
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH,
  parameter int LEN_W     = DEF_LEN_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [LEN_W-1:0]     in_e_len,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [WIDTH-1:0]     in_r2,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy
);

  // ONE from the package, sized to this instance's WIDTH.
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  state_t               state;
  phase_t               phase;
  logic [WIDTH-1:0]     x_reg;
  logic [EXP_WIDTH-1:0] e_reg;
  logic [WIDTH-1:0]     m_reg;
  logic [WIDTH-1:0]     r2_reg;
  logic                 len_zero;
  logic [LEN_W-1:0]     i_reg;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     xt_reg;

  logic                 mont_start;
  logic [WIDTH-1:0]     mont_a;
  logic [WIDTH-1:0]     mont_b;
  logic [WIDTH-1:0]     mont_result;
  logic                 mont_done;
  logic                 e_bit;

  assign e_bit = 1'(e_reg >> i_reg);

  assign mont_start = (phase == PH_ISSUE) &&
                      (state inside {ST_TOMONT, ST_SQ, ST_MUL, ST_FROMMONT});

  // Operands depend only on state and registers, so they stay stable for the
  // whole ISSUE/WAIT span of a multiply.
  always_comb begin
    mont_a = a_reg;
    mont_b = ONE_W;
    case (state)
      ST_TOMONT: begin
        mont_a = x_reg;
        mont_b = r2_reg;
      end
      ST_SQ:       mont_b = a_reg;
      ST_MUL:      mont_b = xt_reg;
      ST_FROMMONT: mont_b = ONE_W;
      default:     mont_b = ONE_W;
    endcase
  end

  montgomery #(
    .WIDTH (WIDTH)
  ) mont_inst (
    .clk    (clk),
    .resetn (resetn),
    .start  (mont_start),
    .in_a   (mont_a),
    .in_b   (mont_b),
    .in_m   (m_reg),
    .result (mont_result),
    .done   (mont_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      phase    <= PH_ISSUE;
      x_reg    <= '0;
      e_reg    <= '0;
      m_reg    <= '0;
      r2_reg   <= '0;
      len_zero <= 1'b0;
      i_reg    <= '0;
      a_reg    <= '0;
      xt_reg   <= '0;
      result   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_reg    <= in_x;
            e_reg    <= in_e;
            m_reg    <= in_m;
            r2_reg   <= in_r2;
            // A starts as R mod m (Montgomery form of 1); no multiply needed.
            a_reg    <= in_r;
            len_zero <= (in_e_len == '0);
            // Wraps when len is 0; unused in that case since SQ/MUL are skipped.
            i_reg    <= in_e_len - LEN_W'(1);
            busy     <= 1'b1;
            phase    <= PH_ISSUE;
            state    <= ST_TOMONT;
          end
        end

        ST_TOMONT: begin
          if (phase == PH_ISSUE) begin
            phase <= PH_WAIT;
          end else if (mont_done) begin
            phase  <= PH_ISSUE;
            xt_reg <= mont_result;
            state  <= len_zero ? ST_FROMMONT : ST_SQ;
          end
        end

        ST_SQ: begin
          if (phase == PH_ISSUE) begin
            phase <= PH_WAIT;
          end else if (mont_done) begin
            phase <= PH_ISSUE;
            a_reg <= mont_result;
            if (e_bit) begin
              state <= ST_MUL;
            end else if (i_reg == '0) begin
              state <= ST_FROMMONT;
            end else begin
              i_reg <= i_reg - LEN_W'(1);
              state <= ST_SQ;
            end
          end
        end

        ST_MUL: begin
          if (phase == PH_ISSUE) begin
            phase <= PH_WAIT;
          end else if (mont_done) begin
            phase <= PH_ISSUE;
            a_reg <= mont_result;
            if (i_reg == '0) begin
              state <= ST_FROMMONT;
            end else begin
              i_reg <= i_reg - LEN_W'(1);
              state <= ST_SQ;
            end
          end
        end

        ST_FROMMONT: begin
          if (phase == PH_ISSUE) begin
            phase <= PH_WAIT;
          end else if (mont_done) begin
            phase <= PH_ISSUE;
            a_reg <= mont_result;
            // Result and done are registered on entry to DONE so that both
            // are visible during the single DONE cycle.
            result <= mont_result;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Directed bench for modexp_ctrl at a small width (24-bit operands).
module tb_modexp_ctrl;
  import modexp_pkg::*;

  localparam int W  = 24;
  localparam int EW = 16;
  localparam int LW = 5;
  localparam int LM = W + 2;  // montgomery start-to-done cycles

  // m = 1000003: R = 2^24 mod m = 777168, R^2 mod m = 288260
  localparam logic [W-1:0] M1  = 24'd1000003;
  localparam logic [W-1:0] R1  = 24'd777168;
  localparam logic [W-1:0] RR1 = 24'd288260;
  // m = 7: 2^24 mod 7 = 1, so R and R^2 are both 1
  localparam logic [W-1:0] M7  = 24'd7;

  logic          clk;
  logic          resetn;
  logic          start;
  logic [W-1:0]  in_x;
  logic [EW-1:0] in_e;
  logic [LW-1:0] in_e_len;
  logic [W-1:0]  in_m;
  logic [W-1:0]  in_r;
  logic [W-1:0]  in_r2;
  logic [W-1:0]  result;
  logic          done;
  logic          busy;

  int checks = 0;
  int errors = 0;

  modexp_ctrl #(
    .WIDTH     (W),
    .EXP_WIDTH (EW),
    .LEN_W     (LW)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .in_x     (in_x),
    .in_e     (in_e),
    .in_e_len (in_e_len),
    .in_m     (in_m),
    .in_r     (in_r),
    .in_r2    (in_r2),
    .result   (result),
    .done     (done),
    .busy     (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    in_x     = W'($urandom_range(0, 32'hFFFFFF));
    in_e     = EW'($urandom_range(0, 32'hFFFF));
    in_e_len = LW'($urandom_range(0, 31));
    in_m     = W'($urandom_range(0, 32'hFFFFFF));
    in_r     = W'($urandom_range(0, 32'hFFFFFF));
    in_r2    = W'($urandom_range(0, 32'hFFFFFF));
  endtask

  // Drive one exponentiation and check result, latency, busy and done shape.
  task automatic run_vec(input string tag, input logic [W-1:0] x, input logic [EW-1:0] e,
                         input logic [LW-1:0] len, input logic [W-1:0] m,
                         input logic [W-1:0] r, input logic [W-1:0] r2,
                         input logic [W-1:0] exp_res, input int n_mm, input bit mid_start);
    int lat;
    bit busy_ok;
    @(negedge clk);
    in_x = x; in_e = e; in_e_len = len; in_m = m; in_r = r; in_r2 = r2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 3000) begin
      if (!busy) busy_ok = 1'b0;
      start = (mid_start && lat == 20);
      if (start) in_x = 24'd3;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(1 + n_mm * (LM + 1)));
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    check({tag, "_busy_cont"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    check({tag, "_done_single"}, 32'(done), 32'd0);
    check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_result_hold"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    scramble_inputs();
    repeat (3) @(negedge clk);
    check("rst_result", 32'(result), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // 2^10 mod 1000003 = 1024; N = 2 + 4 + 2
    run_vec("v1", 24'd2, 16'hA, 5'd4, M1, R1, RR1, 24'h400, 8, 1'b0);
    // e = 0: two multiplies only, result 1
    run_vec("v2", 24'd5, 16'h0, 5'd0, M7, 24'd1, 24'd1, 24'h1, 2, 1'b0);
    // (m-1)^2 = 1 mod m; N = 2 + 2 + 1
    run_vec("v3", M1 - 24'd1, 16'h2, 5'd2, M1, R1, RR1, 24'h1, 5, 1'b0);
    // 5^1 mod 7 = 5; N = 2 + 1 + 1
    run_vec("v4", 24'd5, 16'h1, 5'd1, M7, 24'd1, 24'd1, 24'h5, 4, 1'b0);
    // 3^13 = 1594323 -> 594320 mod 1000003; N = 2 + 4 + 3
    run_vec("v5", 24'd3, 16'hD, 5'd4, M1, R1, RR1, 24'd594320, 9, 1'b0);
    // full-length exponent, only the top bit set; N = 2 + 16 + 1
    run_vec("v6", 24'd1, 16'h8000, 5'd16, M1, R1, RR1, 24'h1, 19, 1'b0);
    // second start mid-run must be ignored
    run_vec("v7", 24'd2, 16'hA, 5'd4, M1, R1, RR1, 24'h400, 8, 1'b1);

    // Reset during the WAIT of the first SQ (TOMONT spans cycles 1..27).
    @(negedge clk);
    in_x = 24'd2; in_e = 16'hA; in_e_len = 5'd4; in_m = M1; in_r = R1; in_r2 = RR1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    check("pre_rst_state", 32'(dut.state), 32'(ST_SQ));
    check("pre_rst_phase", 32'(dut.phase), 32'(PH_WAIT));
    resetn = 1'b0;
    #1;
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_vec("v8", 24'd2, 16'hA, 5'd4, M1, R1, RR1, 24'h400, 8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

- Left-to-right square-and-multiply modular exponentiation controller: result = x^e mod m for WIDTH-bit operands.
- Sits directly upstream of `montgomery` and owns one instance of it. It sequences every multiplication: issues `start`, holds `in_a`/`in_b`/`in_m`, and consumes `result` on `done`.
- Host (software/driver) supplies precomputed R mod m and R² mod m, with R = 2^WIDTH.

## Interface

Parameters:
- WIDTH, 1024 — operand/modulus width; must match `montgomery`.
- EXP_WIDTH, 1024 — exponent register width.
- LEN_W, 11 — width of `in_e_len`; must hold values 0..EXP_WIDTH.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset; also drives the `montgomery` instance.
- start  in  1  one-cycle request; sampled only in IDLE.
- in_x  in  WIDTH  base, normal domain; requires x < m.
- in_e  in  EXP_WIDTH  exponent.
- in_e_len  in  LEN_W  significant exponent bits; 0 means e = 0.
- in_m  in  WIDTH  odd modulus.
- in_r  in  WIDTH  R mod m.
- in_r2  in  WIDTH  R² mod m.
- result  out  WIDTH  x^e mod m; held until the next accepted start.
- done  out  1  one-cycle pulse when `result` becomes valid.
- busy  out  1  high from the cycle after an accepted start through the `done` cycle.

## Operation

- Accepted start (IDLE && start):
  - latch all inputs into internal registers;
  - set the bit counter i = in_e_len − 1;
  - go to TOMONT.
  - Inputs may change freely after acceptance.
- States and transitions:
  - IDLE.
  - TOMONT: xt = MM(x, R²). A ← R mod m (loaded in parallel, no multiply). Go to SQ, or to FROMMONT if len = 0.
  - SQ: A = MM(A, A). If e[i] go to MUL; else decrement i and go to SQ, or to FROMMONT when i = 0.
  - MUL: A = MM(A, xt). Decrement i and go to SQ, or to FROMMONT when i = 0.
  - FROMMONT: A = MM(A, 1).
  - DONE: single cycle; drive done = 1, latch result = A, go to IDLE.
- Each MM state has two phases, ISSUE and WAIT:
  - ISSUE (1 cycle): mont_start = 1.
  - WAIT: hold mont_start = 0 and keep operands stable until mont_done = 1. Capture mont_result into the destination register in that same cycle, then take the transition.
- `start` while busy: ignored, no side effects.
- Reset (async, any state, including mid-multiply):
  - state = IDLE;
  - result = 0, done = 0, busy = 0;
  - i, A, xt cleared;
  - the montgomery instance resets with it. No partial result is ever presented.
- Arithmetic: no reduction is performed in this block. All reduction happens in `montgomery`, whose outputs are < m.
- Multiplication count = 2 + len + popcount(e[len−1:0]).

## Timing

- Let Lm = cycles from mont_start high to mont_done high.
- Each MM costs Lm + 1 cycles, ISSUE through capture.
- Latency, from the cycle start is sampled to the done pulse = 1 + N·(Lm + 1), with N = multiplication count.
- len = 0: N = 2, so done occurs at 1 + 2(Lm + 1).
- `busy` deasserts in the cycle after the done pulse, so a new start is accepted from that cycle onward.
- `done` is never asserted for 2 consecutive cycles.
- After `done`, `result` stays stable indefinitely.

## Structure

- Shared package holds:
  - state encoding: IDLE, TOMONT, SQ, MUL, FROMMONT, DONE, plus the ISSUE/WAIT phase bit;
  - the WIDTH/EXP_WIDTH defaults;
  - constant ONE = {WIDTH-1{0}, 1}.
- One sub-module: `montgomery`, instantiated once, name `mont_inst`.
- Operand muxing for in_a/in_b is done in this block; no separate datapath module.

## Test plan

- x=0x2, e=0xA, len=4, m=0xF4243 (1000003), host-computed R/R² → result 0x400. Done exactly once. Latency = 1 + 8(Lm+1).
- x=0x5, e=0x0, len=0, m=0x7 → result 0x1 after exactly 2 MMs.
- x=m−1, e=0x2, len=2, m=0xF4243 → result 0x1. x=0x5, e=0x1, len=1, m=0x7 → result 0x5.
- 1024-bit vector from the Python generator (random odd m, x<m, e with len=1024) → result matches model. Multiplication count = 1026 + popcount(e).
- start pulsed again mid-run with different x → ignored; first result correct; busy continuous.
- resetn low during WAIT of a SQ → outputs 0 immediately, state IDLE. Fresh start afterwards with vector 1 → 0x400.
